ln_norm_sequencer: RTL and testbench
====================================

LN_NORM_SEQUENCER -- requirements
Module: ln_norm_sequencer

Interface
REQ-001 The block SHALL have parameter P, default 32, setting operand/result width.
REQ-002 The block SHALL have parameter CLR_CYC, default 2, setting the datapath-clear pulse length in cycles (legal range 1..15).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, setting the maximum WAIT cycles before error (legal range 1..65535).
REQ-004 The block SHALL have parameter PERIOD, default 1000, setting the auto-trigger interval in cycles (legal range 2..2^20).
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- CLK in 1: single system clock.
- RST in 1: asynchronous, active-high reset.
- START in 1: one-shot conversion request.
- AUTO_EN in 1: periodic trigger enable.
- I_IN in P: float current sample.
- V_IN in P: float voltage sample.
- ACK_I in 1: current-path done, from datapath.
- ACK_V in 1: voltage-path done, from datapath.
- RESULT_I in P: fixed-point current, from datapath.
- RESULT_V in P: fixed-point voltage, from datapath.
- I_OP out P: held current operand, to datapath.
- V_OP out P: held voltage operand, to datapath.
- RST_LN_FF out 1: datapath reset.
- BEGIN_FSM_I out 1: current-path start pulse.
- BEGIN_FSM_V out 1: voltage-path start pulse.
- DATA_I out P: captured current result.
- DATA_V out P: captured voltage result.
- VALID out 1: one-cycle result strobe.
- BUSY out 1: conversion in progress.
- TIMEOUT_ERR out 1: sticky timeout flag.

Function
REQ-006 The FSM SHALL have states IDLE, CLEAR, LAUNCH, WAIT, DONE and ERR; all outputs SHALL be registered.
REQ-007 The trigger SHALL be START, or the auto-trigger tick when AUTO_EN=1; the FSM SHALL accept a trigger only in IDLE, and a trigger arriving in any other state SHALL be dropped, not queued.
REQ-008 The auto-trigger counter SHALL count 0..PERIOD-1 while AUTO_EN=1, tick at the wrap, and clear to 0 when AUTO_EN=0.
REQ-009 On an accepted trigger, I_IN and V_IN SHALL be latched into I_OP and V_OP, which SHALL hold stable until the next accepted trigger.
REQ-010 The FSM SHALL move from IDLE to CLEAR and assert RST_LN_FF for exactly CLR_CYC cycles.
REQ-011 The FSM SHALL then enter LAUNCH for one cycle, asserting BEGIN_FSM_I and BEGIN_FSM_V together for exactly that cycle.
REQ-012 In WAIT, ACK_I and ACK_V SHALL be collected into sticky flags, arriving in either order, in the same cycle, or repeatedly.
REQ-013 The cycle in which both flags are set (counting the current-cycle ACK) SHALL move the FSM to DONE.
REQ-014 In DONE, DATA_I and DATA_V SHALL be loaded with the RESULT values sampled on each path's ACK cycle, VALID SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-015 Latency SHALL be: trigger at cycle 0; RST_LN_FF high for cycles 1..CLR_CYC; BEGIN pulses at cycle CLR_CYC+1; VALID one cycle after the last ACK.
REQ-016 A 16-bit watchdog SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT without both ACKs SHALL move the FSM to ERR.
REQ-017 In ERR, TIMEOUT_ERR SHALL set, RST_LN_FF SHALL be high for one cycle, VALID SHALL stay low and DATA_I/DATA_V SHALL be unchanged; the FSM SHALL then go to IDLE.
REQ-018 TIMEOUT_ERR SHALL stay set until the next accepted trigger or RST.
REQ-019 ACKs arriving outside WAIT SHALL be ignored.
REQ-020 BUSY SHALL be high in every state except IDLE.

Reset
REQ-021 While RST=1, the state SHALL be IDLE; all counters, flags, I_OP, V_OP, DATA_I, DATA_V, VALID, BUSY, BEGIN_FSM_I, BEGIN_FSM_V and TIMEOUT_ERR SHALL be 0; and RST_LN_FF SHALL be 1.
REQ-022 After RST deasserts, RST_LN_FF SHALL be low from the first clock edge in IDLE.
REQ-023 RST asserted mid-conversion SHALL abort immediately with no VALID pulse.

Structure
REQ-024 A shared package SHALL hold the state encoding (3-bit), the default values of CLR_CYC, TIMEOUT and PERIOD, and the watchdog width.
REQ-025 The auto-trigger tick generator SHALL be a separate sub-module, ln_period_tick (inputs CLK, RST, EN; output TICK; parameter PERIOD).

Verification
REQ-026 START at cycle 0 with I_IN=0x3F800000, V_IN=0x40000000, ACK_V at WAIT+3, ACK_I at WAIT+10 with RESULT_I=0x00010000, RESULT_V=0x00020000 -> RST_LN_FF high in cycles 1-2, BEGIN pulses at cycle 3, VALID at cycle 15, DATA_I=0x00010000, DATA_V=0x00020000.
REQ-027 ACK_I and ACK_V in the same cycle -> VALID exactly one cycle later, a single pulse.
REQ-028 No ACK_I with TIMEOUT=20 -> ERR after 20 WAIT cycles, TIMEOUT_ERR=1, no VALID, DATA_I/DATA_V unchanged; the next START clears TIMEOUT_ERR.
REQ-029 AUTO_EN=1, PERIOD=50, ACKs 5 cycles after BEGIN -> one VALID per 50 cycles; START pulses while BUSY produce no extra conversion.
REQ-030 RST asserted during WAIT -> all outputs at reset values within the same cycle, RST_LN_FF=1, no VALID after release.

Source files
------------

// File: rtl/ln_norm_sequencer_pkg.sv
// Shared definitions for the ln_norm conversion sequencer: state encoding,
// parameter defaults and counter widths.
package ln_norm_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam int unsigned CLR_CYC_DEF = 2;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned PERIOD_DEF  = 1000;

  localparam int unsigned WDOG_W = 16;
  // CLR_CYC is limited to 1..15, so a 4-bit down-counter covers it
  localparam int unsigned CLR_W  = 4;

endpackage

// File: rtl/ln_period_tick.sv
// Free-running auto-trigger generator: counts 0..PERIOD-1 while enabled and
// emits a one-cycle registered TICK on each wrap.
module ln_period_tick
  import ln_norm_sequencer_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else if (!EN) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      TICK <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      TICK <= 1'b0;
    end
  end

endmodule

// File: rtl/ln_norm_sequencer.sv
// Sequences one ln_norm datapath conversion: latch operands, clear the
// datapath, launch both paths, collect ACKs under a watchdog, publish results.
//
// state  | meaning
// IDLE   | waiting for START or auto tick
// CLEAR  | RST_LN_FF held high for CLR_CYC cycles
// LAUNCH | one-cycle BEGIN_FSM_I/BEGIN_FSM_V pulse
// WAIT   | collecting ACK_I/ACK_V, watchdog running
// DONE   | results published, VALID high
// ERR    | watchdog expired, datapath reset for one cycle
module ln_norm_sequencer
  import ln_norm_sequencer_pkg::*;
#(
  parameter int unsigned P       = 32,
  parameter int unsigned CLR_CYC = CLR_CYC_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned PERIOD  = PERIOD_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         AUTO_EN,
  input  logic [P-1:0] I_IN,
  input  logic [P-1:0] V_IN,
  input  logic         ACK_I,
  input  logic         ACK_V,
  input  logic [P-1:0] RESULT_I,
  input  logic [P-1:0] RESULT_V,
  output logic [P-1:0] I_OP,
  output logic [P-1:0] V_OP,
  output logic         RST_LN_FF,
  output logic         BEGIN_FSM_I,
  output logic         BEGIN_FSM_V,
  output logic [P-1:0] DATA_I,
  output logic [P-1:0] DATA_V,
  output logic         VALID,
  output logic         BUSY,
  output logic         TIMEOUT_ERR
);

  localparam logic [CLR_W-1:0]  CLR_LOAD  = CLR_W'(CLR_CYC - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_t            state_q, state_n;
  logic [CLR_W-1:0]  clr_q, clr_n;
  logic [WDOG_W-1:0] wdog_q, wdog_n;
  logic              ack_i_q, ack_i_n, ack_v_q, ack_v_n;
  logic [P-1:0]      res_i_q, res_i_n, res_v_q, res_v_n;
  logic [P-1:0]      i_op_n, v_op_n, data_i_n, data_v_n;
  logic              rst_ln_n, begin_n, valid_n, busy_n, terr_n;
  logic              tick, trig, got_i, got_v;

  ln_period_tick #(
    .PERIOD(PERIOD)
  ) u_tick (
    .CLK (CLK),
    .RST (RST),
    .EN  (AUTO_EN),
    .TICK(tick)
  );

  assign trig  = START | (AUTO_EN & tick);
  // completion counts an ACK arriving in the current cycle
  assign got_i = ack_i_q | ACK_I;
  assign got_v = ack_v_q | ACK_V;

  always_comb begin
    state_n  = state_q;
    clr_n    = clr_q;
    wdog_n   = wdog_q;
    ack_i_n  = ack_i_q;
    ack_v_n  = ack_v_q;
    res_i_n  = res_i_q;
    res_v_n  = res_v_q;
    i_op_n   = I_OP;
    v_op_n   = V_OP;
    data_i_n = DATA_I;
    data_v_n = DATA_V;
    terr_n   = TIMEOUT_ERR;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_n = ST_CLEAR;
          clr_n   = CLR_LOAD;
          i_op_n  = I_IN;
          v_op_n  = V_IN;
          terr_n  = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (clr_q == '0) state_n = ST_LAUNCH;
        else             clr_n   = clr_q - 1'b1;
      end
      ST_LAUNCH: begin
        state_n = ST_WAIT;
        wdog_n  = '0;
        ack_i_n = 1'b0;
        ack_v_n = 1'b0;
      end
      ST_WAIT: begin
        wdog_n = wdog_q + 1'b1;
        if (ACK_I && !ack_i_q) begin
          ack_i_n = 1'b1;
          res_i_n = RESULT_I;
        end
        if (ACK_V && !ack_v_q) begin
          ack_v_n = 1'b1;
          res_v_n = RESULT_V;
        end
        // completion wins over a watchdog expiring in the same cycle
        if (got_i && got_v) begin
          state_n  = ST_DONE;
          data_i_n = ack_i_q ? res_i_q : RESULT_I;
          data_v_n = ack_v_q ? res_v_q : RESULT_V;
        end else if (wdog_q == WDOG_LAST) begin
          state_n = ST_ERR;
          terr_n  = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    rst_ln_n = (state_n == ST_CLEAR) || (state_n == ST_ERR);
    begin_n  = (state_n == ST_LAUNCH);
    valid_n  = (state_n == ST_DONE);
    busy_n   = (state_n != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      clr_q       <= '0;
      wdog_q      <= '0;
      ack_i_q     <= 1'b0;
      ack_v_q     <= 1'b0;
      res_i_q     <= '0;
      res_v_q     <= '0;
      I_OP        <= '0;
      V_OP        <= '0;
      DATA_I      <= '0;
      DATA_V      <= '0;
      RST_LN_FF   <= 1'b1;
      BEGIN_FSM_I <= 1'b0;
      BEGIN_FSM_V <= 1'b0;
      VALID       <= 1'b0;
      BUSY        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state_q     <= state_n;
      clr_q       <= clr_n;
      wdog_q      <= wdog_n;
      ack_i_q     <= ack_i_n;
      ack_v_q     <= ack_v_n;
      res_i_q     <= res_i_n;
      res_v_q     <= res_v_n;
      I_OP        <= i_op_n;
      V_OP        <= v_op_n;
      DATA_I      <= data_i_n;
      DATA_V      <= data_v_n;
      RST_LN_FF   <= rst_ln_n;
      BEGIN_FSM_I <= begin_n;
      BEGIN_FSM_V <= begin_n;
      VALID       <= valid_n;
      BUSY        <= busy_n;
      TIMEOUT_ERR <= terr_n;
    end
  end

endmodule

// File: tb/tb_ln_norm_sequencer.sv
// Self-checking bench for ln_norm_sequencer: timeline model of a conversion
// compared against per-cycle traces of the registered outputs.
module tb_ln_norm_sequencer;

  localparam int P   = 32;
  localparam int CLR = 2;
  localparam int TO  = 20;
  localparam int PER = 50;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         AUTO_EN = 1'b0;
  logic [P-1:0] I_IN = '0;
  logic [P-1:0] V_IN = '0;
  logic         ACK_I = 1'b0;
  logic         ACK_V = 1'b0;
  logic [P-1:0] RESULT_I = '0;
  logic [P-1:0] RESULT_V = '0;
  logic [P-1:0] I_OP, V_OP, DATA_I, DATA_V;
  logic         RST_LN_FF, BEGIN_FSM_I, BEGIN_FSM_V, VALID, BUSY, TIMEOUT_ERR;

  int errors = 0;
  int checks = 0;

  logic [63:0] tr_rst, tr_beg_i, tr_beg_v, tr_valid, tr_busy, tr_terr;
  logic [63:0] ex_rst, ex_beg, ex_valid, ex_busy;
  logic        ex_ok;
  int          ex_end;
  logic        op_ok;
  logic [P-1:0] exp_di = '0;
  logic [P-1:0] exp_dv = '0;

  ln_norm_sequencer #(
    .P(P), .CLR_CYC(CLR), .TIMEOUT(TO), .PERIOD(PER)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .AUTO_EN(AUTO_EN),
    .I_IN(I_IN), .V_IN(V_IN), .ACK_I(ACK_I), .ACK_V(ACK_V),
    .RESULT_I(RESULT_I), .RESULT_V(RESULT_V),
    .I_OP(I_OP), .V_OP(V_OP), .RST_LN_FF(RST_LN_FF),
    .BEGIN_FSM_I(BEGIN_FSM_I), .BEGIN_FSM_V(BEGIN_FSM_V),
    .DATA_I(DATA_I), .DATA_V(DATA_V), .VALID(VALID), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // Timeline model: trigger in cycle 0, clear 1..CLR, launch CLR+1, WAIT from
  // CLR+2 for TO cycles; only the first ACK of each path inside WAIT counts.
  function automatic int first_in(input int a, input int b, input int lo, input int hi);
    int f = -1;
    if (a >= lo && a <= hi) f = a;
    if (b >= lo && b <= hi && (f < 0 || b < f)) f = b;
    return f;
  endfunction

  task automatic model_conv(input int ai0, input int ai1, input int av0, input int av1);
    int w, fi, fv;
    w = CLR + 2;
    ex_rst = '0; ex_beg = '0; ex_valid = '0; ex_busy = '0;
    for (int k = 1; k <= CLR; k++) ex_rst[k] = 1'b1;
    ex_beg[CLR+1] = 1'b1;
    fi = first_in(ai0, ai1, w, w + TO - 1);
    fv = first_in(av0, av1, w, w + TO - 1);
    if (fi >= 0 && fv >= 0) begin
      ex_ok  = 1'b1;
      ex_end = ((fi > fv) ? fi : fv) + 1;
      ex_valid[ex_end] = 1'b1;
    end else begin
      ex_ok  = 1'b0;
      ex_end = w + TO;
      ex_rst[ex_end] = 1'b1;
    end
    for (int k = 1; k <= ex_end; k++) ex_busy[k] = 1'b1;
  endtask

  // Runs n cycles from posedge+1; cycle 0 carries START when requested.
  task automatic run_conv(input logic do_start, input int ai0, input int ai1,
                          input int av0, input int av1,
                          input logic [P-1:0] ii, input logic [P-1:0] vi,
                          input logic [P-1:0] ri, input logic [P-1:0] rv,
                          input int n);
    tr_rst = '0; tr_beg_i = '0; tr_beg_v = '0; tr_valid = '0; tr_busy = '0; tr_terr = '0;
    op_ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      START    = do_start && (k == 0);
      I_IN     = (k == 0) ? ii : $urandom;
      V_IN     = (k == 0) ? vi : $urandom;
      ACK_I    = (k == ai0) || (k == ai1);
      ACK_V    = (k == av0) || (k == av1);
      RESULT_I = ACK_I ? ri : $urandom;
      RESULT_V = ACK_V ? rv : $urandom;
      @(negedge CLK);
      tr_rst[k]   = RST_LN_FF;
      tr_beg_i[k] = BEGIN_FSM_I;
      tr_beg_v[k] = BEGIN_FSM_V;
      tr_valid[k] = VALID;
      tr_busy[k]  = BUSY;
      tr_terr[k]  = TIMEOUT_ERR;
      if (do_start && k >= 1 && (I_OP !== ii || V_OP !== vi)) op_ok = 1'b0;
      @(posedge CLK); #1;
    end
    START = 1'b0; ACK_I = 1'b0; ACK_V = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (RST_LN_FF !== 1'b1) begin errors++; $display("FAIL reset_rst_ln_ff: got %b expected 1", RST_LN_FF); end
    checks++;
    if ({VALID, BUSY, BEGIN_FSM_I, BEGIN_FSM_V, TIMEOUT_ERR} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {VALID, BUSY, BEGIN_FSM_I, BEGIN_FSM_V, TIMEOUT_ERR});
    end
    checks++;
    if ({I_OP, V_OP, DATA_I, DATA_V} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected all zero", I_OP, V_OP, DATA_I, DATA_V);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (RST_LN_FF !== 1'b1) begin errors++; $display("FAIL release_before_edge: got %b expected 1", RST_LN_FF); end
    @(negedge CLK);
    checks++;
    if (RST_LN_FF !== 1'b0) begin errors++; $display("FAIL release_first_edge: got %b expected 0", RST_LN_FF); end
    @(posedge CLK); #1;
  endtask

  task automatic test_spec_example;
    model_conv(14, -1, 7, -1);
    run_conv(1'b1, 14, -1, 7, -1, 32'h3F800000, 32'h40000000, 32'h00010000, 32'h00020000, 24);
    checks++;
    if (tr_rst !== 64'h6) begin errors++; $display("FAIL ex_rst_ln_ff: got %h expected %h", tr_rst, 64'h6); end
    checks++;
    if (tr_beg_i !== (64'd1 << 3) || tr_beg_v !== (64'd1 << 3)) begin
      errors++; $display("FAIL ex_begin: got %h/%h expected %h", tr_beg_i, tr_beg_v, 64'd1 << 3);
    end
    checks++;
    if (tr_valid !== (64'd1 << 15)) begin errors++; $display("FAIL ex_valid: got %h expected %h", tr_valid, 64'd1 << 15); end
    checks++;
    if (tr_busy !== ex_busy) begin errors++; $display("FAIL ex_busy: got %h expected %h", tr_busy, ex_busy); end
    checks++;
    if (DATA_I !== 32'h00010000) begin errors++; $display("FAIL ex_data_i: got %h expected 00010000", DATA_I); end
    checks++;
    if (DATA_V !== 32'h00020000) begin errors++; $display("FAIL ex_data_v: got %h expected 00020000", DATA_V); end
    checks++;
    if (!op_ok) begin errors++; $display("FAIL ex_operand_hold: got %h/%h expected 3f800000/40000000", I_OP, V_OP); end
    checks++;
    if (tr_terr !== '0) begin errors++; $display("FAIL ex_timeout_err: got %h expected 0", tr_terr); end
    exp_di = 32'h00010000;
    exp_dv = 32'h00020000;
  endtask

  task automatic test_ack_orders;
    int pat [5][4];
    int ai0, ai1, av0, av1;
    logic [P-1:0] ri, rv, ii, vi;
    pat = '{'{6, -1, 6, -1}, '{5, 9, 7, 12}, '{2, -1, 8, -1}, '{17, -1, 4, -1}, '{23, -1, 10, -1}};
    for (int it = 0; it < 11; it++) begin
      if (it < 5) begin
        ai0 = pat[it][0]; ai1 = pat[it][1]; av0 = pat[it][2]; av1 = pat[it][3];
      end else begin
        ai0 = 4 + $urandom_range(0, 14);
        av0 = 4 + $urandom_range(0, 14);
        ai1 = -1;
        av1 = av0 + $urandom_range(1, 5);
      end
      ri = $urandom; rv = $urandom; ii = $urandom; vi = $urandom;
      model_conv(ai0, ai1, av0, av1);
      run_conv(1'b1, ai0, ai1, av0, av1, ii, vi, ri, rv, 30);
      if (ex_ok) begin exp_di = ri; exp_dv = rv; end
      checks++;
      if (tr_valid !== ex_valid) begin errors++; $display("FAIL ord%0d_valid: got %h expected %h", it, tr_valid, ex_valid); end
      checks++;
      if (tr_busy !== ex_busy) begin errors++; $display("FAIL ord%0d_busy: got %h expected %h", it, tr_busy, ex_busy); end
      checks++;
      if (tr_rst !== ex_rst) begin errors++; $display("FAIL ord%0d_rst_ln_ff: got %h expected %h", it, tr_rst, ex_rst); end
      checks++;
      if (DATA_I !== exp_di || DATA_V !== exp_dv) begin
        errors++; $display("FAIL ord%0d_data: got %h/%h expected %h/%h", it, DATA_I, DATA_V, exp_di, exp_dv);
      end
      checks++;
      if (TIMEOUT_ERR !== !ex_ok) begin errors++; $display("FAIL ord%0d_timeout_err: got %b expected %b", it, TIMEOUT_ERR, !ex_ok); end
      checks++;
      if (!op_ok) begin errors++; $display("FAIL ord%0d_operand_hold: got %h/%h expected %h/%h", it, I_OP, V_OP, ii, vi); end
    end
  endtask

  task automatic test_timeout;
    logic [63:0] mask, ex_terr;
    model_conv(-1, -1, 10, -1);
    run_conv(1'b1, -1, -1, 10, -1, $urandom, $urandom, $urandom, $urandom, 30);
    mask    = (64'd1 << 30) - 64'd2;
    ex_terr = mask & ~((64'd1 << ex_end) - 64'd1);
    checks++;
    if (ex_end != CLR + 2 + TO || tr_rst !== ex_rst) begin errors++; $display("FAIL to_rst_ln_ff: got %h expected %h", tr_rst, ex_rst); end
    checks++;
    if (tr_busy !== ex_busy) begin errors++; $display("FAIL to_busy: got %h expected %h", tr_busy, ex_busy); end
    checks++;
    if (tr_valid !== '0) begin errors++; $display("FAIL to_no_valid: got %h expected 0", tr_valid); end
    checks++;
    if (DATA_I !== exp_di || DATA_V !== exp_dv) begin
      errors++; $display("FAIL to_data_held: got %h/%h expected %h/%h", DATA_I, DATA_V, exp_di, exp_dv);
    end
    checks++;
    if ((tr_terr & mask) !== ex_terr) begin errors++; $display("FAIL to_err_flag: got %h expected %h", tr_terr & mask, ex_terr); end
    run_conv(1'b1, 6, -1, 6, -1, $urandom, $urandom, 32'h11112222, 32'h33334444, 12);
    checks++;
    if (tr_terr[0] !== 1'b1 || tr_terr[1] !== 1'b0) begin
      errors++; $display("FAIL to_err_cleared: got %b%b expected 10", tr_terr[0], tr_terr[1]);
    end
    checks++;
    if (tr_valid !== (64'd1 << 7)) begin errors++; $display("FAIL same_cycle_valid: got %h expected %h", tr_valid, 64'd1 << 7); end
    exp_di = 32'h11112222;
    exp_dv = 32'h33334444;
    checks++;
    if (DATA_I !== exp_di || DATA_V !== exp_dv) begin
      errors++; $display("FAIL same_cycle_data: got %h/%h expected %h/%h", DATA_I, DATA_V, exp_di, exp_dv);
    end
  endtask

  task automatic test_auto_trigger;
    int valid_q[$];
    int beg_seen, n_begin, ph;
    logic [P-1:0] last_ri;
    beg_seen = -100; n_begin = 0; last_ri = exp_di;
    AUTO_EN = 1'b1;
    for (int r = 0; r < 280; r++) begin
      ph = r % PER;
      START    = (r > PER) && (ph >= 1) && (ph <= 8) && ($urandom_range(0, 1) == 1);
      ACK_I    = (r == beg_seen + 5);
      ACK_V    = ACK_I;
      RESULT_I = $urandom;
      RESULT_V = $urandom;
      if (ACK_I) last_ri = RESULT_I;
      @(negedge CLK);
      if (BEGIN_FSM_I === 1'b1) begin beg_seen = r; n_begin++; end
      if (VALID === 1'b1) valid_q.push_back(r);
      @(posedge CLK); #1;
    end
    AUTO_EN = 1'b0; START = 1'b0; ACK_I = 1'b0; ACK_V = 1'b0;
    checks++;
    if (n_begin != 5) begin errors++; $display("FAIL auto_launch_count: got %0d expected 5", n_begin); end
    checks++;
    if (valid_q.size() != 5) begin errors++; $display("FAIL auto_valid_count: got %0d expected 5", valid_q.size()); end
    checks++;
    if (valid_q.size() == 0 || valid_q[0] != PER + CLR + 7) begin
      errors++; $display("FAIL auto_first_valid: got %0d expected %0d", (valid_q.size() > 0) ? valid_q[0] : -1, PER + CLR + 7);
    end
    for (int i = 1; i < valid_q.size(); i++) begin
      checks++;
      if (valid_q[i] - valid_q[i-1] != PER) begin
        errors++; $display("FAIL auto_spacing%0d: got %0d expected %0d", i, valid_q[i] - valid_q[i-1], PER);
      end
    end
    checks++;
    if (DATA_I !== last_ri) begin errors++; $display("FAIL auto_data_i: got %h expected %h", DATA_I, last_ri); end
  endtask

  task automatic test_reset_mid;
    logic saw_valid, saw_busy;
    for (int k = 0; k < 6; k++) begin
      START = (k == 0);
      I_IN  = $urandom;
      V_IN  = $urandom;
      @(negedge CLK);
      @(posedge CLK); #1;
    end
    START = 1'b0;
    RST = 1'b1;
    #1;
    checks++;
    if (BUSY !== 1'b0 || RST_LN_FF !== 1'b1) begin
      errors++; $display("FAIL mid_reset_ctrl: got busy=%b rst_ln_ff=%b expected 0/1", BUSY, RST_LN_FF);
    end
    checks++;
    if ({VALID, BEGIN_FSM_I, BEGIN_FSM_V, TIMEOUT_ERR} !== 4'b0) begin
      errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {VALID, BEGIN_FSM_I, BEGIN_FSM_V, TIMEOUT_ERR});
    end
    checks++;
    if ({I_OP, V_OP, DATA_I, DATA_V} !== '0) begin
      errors++; $display("FAIL mid_reset_data: got %h %h %h %h expected all zero", I_OP, V_OP, DATA_I, DATA_V);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    saw_valid = 1'b0; saw_busy = 1'b0;
    for (int k = 0; k < 25; k++) begin
      ACK_I = (k == 2) || (k == 5);
      ACK_V = (k == 2) || (k == 5);
      @(negedge CLK);
      if (VALID !== 1'b0) saw_valid = 1'b1;
      if (BUSY !== 1'b0) saw_busy = 1'b1;
      @(posedge CLK); #1;
    end
    ACK_I = 1'b0; ACK_V = 1'b0;
    checks++;
    if (saw_valid || saw_busy) begin
      errors++; $display("FAIL mid_reset_no_valid: got valid=%b busy=%b expected 0/0", saw_valid, saw_busy);
    end
  endtask

  initial begin
    test_reset();
    test_spec_example();
    test_ack_orders();
    test_timeout();
    test_auto_trigger();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
